// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative shift/rotate unit (SLL/SRL/SRA/ROR), up to STEP bits per clock
// Loads on start in IDLE, shifts min(rem, STEP) bits per cycle, pulses done for one cycle.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  // One extra bit so STEP == WIDTH and WIDTH - k are representable.
  localparam int KW = SHAMT_W + 1;
  localparam logic [KW-1:0]    STEP_K  = KW'(STEP);
  localparam logic [KW-1:0]    WIDTH_K = KW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES    = '1;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;

  logic [KW-1:0]      rem_ext;
  logic [KW-1:0]      k_amt;
  logic [KW-1:0]      rem_left;
  logic [KW-1:0]      rot_back;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   shifted;

  always_comb begin : step_calc
    rem_ext   = {1'b0, rem_q};
    k_amt     = (rem_ext < STEP_K) ? rem_ext : STEP_K;
    rem_left  = rem_ext - k_amt;
    rot_back  = WIDTH_K - k_amt;
    fill_mask = ~(ONES >> k_amt);
    case (op_q)
      OP_SLL:  shifted = acc_q << k_amt;
      OP_SRL:  shifted = acc_q >> k_amt;
      OP_SRA:  shifted = (acc_q >> k_amt) | (fill_mask & {WIDTH{sign_q}});
      default: shifted = (acc_q >> k_amt) | (acc_q << rot_back);
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_left == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only on an accepted start; later input changes never reach the datapath.
  always_comb begin : datapath_next
    acc_d  = acc_q;
    rem_d  = rem_q;
    op_d   = op_q;
    sign_d = sign_q;
    if (state_q == ST_IDLE && start) begin
      acc_d  = din;
      rem_d  = shamt;
      op_d   = op;
      sign_d = din[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      acc_d = shifted;
      rem_d = rem_left[SHAMT_W-1:0];
    end
  end

  always_comb begin : outputs
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign dout = acc_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter with STEP=1 and STEP=4 instances
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt), .din(din),
    .busy(busy1), .done(done1), .dout(dout1)
  );

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt), .din(din),
    .busy(busy4), .done(done4), .dout(dout4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Whole-operation reference: one-shot arithmetic on the full amount.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s, input logic [31:0] d);
    logic [63:0] dd;
    case (o)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return 32'($signed(d) >>> s);
      default: begin
        dd = {d, d} >> s;
        return dd[31:0];
      end
    endcase
  endfunction

  // inj >= 0: pulse start with fresh random operands at the negedge after edge inj.
  task automatic run_op(input string tag, input logic [1:0] o, input int s,
                        input logic [31:0] d, input logic [31:0] exp, input int inj);
    int n1, n4, dn1, dn4, de1, de4, b1, b4;
    logic [31:0] r1, r4;
    n1 = s; n4 = (s + 3) / 4;
    dn1 = 0; dn4 = 0; de1 = -1; de4 = -1; b1 = 0; b4 = 0; r1 = '0; r4 = '0;
    @(negedge clk);
    op = o; shamt = 5'(s); din = d; start = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= n1 + 2; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (e == inj) begin
        start = 1'b1;
        op    = 2'($urandom);
        shamt = 5'($urandom);
        din   = $urandom;
      end
      if (busy1) b1++;
      if (busy4) b4++;
      if (done1) begin dn1++; de1 = e; r1 = dout1; end
      if (done4) begin dn4++; de4 = e; r4 = dout4; end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "/s1_dout"},      r1,  exp);
    check({tag, "/s1_done_cnt"},  dn1, 1);
    check({tag, "/s1_done_edge"}, de1, n1);
    check({tag, "/s1_busy_cyc"},  b1,  n1 + 1);
    check({tag, "/s1_hold"},      dout1, exp);
    check({tag, "/s1_idle"},      busy1, 0);
    check({tag, "/s4_dout"},      r4,  exp);
    check({tag, "/s4_done_cnt"},  dn4, 1);
    check({tag, "/s4_done_edge"}, de4, n4);
    check({tag, "/s4_busy_cyc"},  b4,  n4 + 1);
    check({tag, "/s4_hold"},      dout4, exp);
    check({tag, "/s4_idle"},      busy4, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/s1_busy"}, busy1, 0);
    check({tag, "/s1_done"}, done1, 0);
    check({tag, "/s1_dout"}, dout1, 0);
    check({tag, "/s4_busy"}, busy4, 0);
    check({tag, "/s4_done"}, done4, 0);
    check({tag, "/s4_dout"}, dout4, 0);
  endtask

  initial begin
    int stray;
    logic [1:0]  ro;
    int          rs, rinj;
    logic [31:0] rd;

    reset = 1'b1; start = 1'b0; op = '0; shamt = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    run_op("sll31",  2'd0, 31, 32'h0000_0001, 32'h8000_0000, -1);
    run_op("sra4",   2'd2, 4,  32'h8000_0000, 32'hF800_0000, -1);
    run_op("srl4",   2'd1, 4,  32'h8000_0000, 32'h0800_0000, -1);
    run_op("ror8",   2'd3, 8,  32'h1234_5678, 32'h7812_3456, -1);
    run_op("zero",   2'($urandom), 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, -1);
    run_op("srl7",   2'd1, 7,  32'hFFFF_FFFF, 32'h01FF_FFFF, -1);
    run_op("inj_sh", 2'd0, 20, 32'h0000_ABCD, 32'hBCD0_0000, 2);
    run_op("inj_dn", 2'd3, 12, 32'hA5A5_0F0F, 32'hF0FA_5A50, 3);

    // Reset mid-SHIFT: everything clears and the old operation never completes.
    @(negedge clk);
    op = 2'd0; shamt = 5'd20; din = 32'h1357_9BDF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_mid");
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) stray++;
    end
    check("rst_no_done", stray, 0);
    run_op("after_rst", 2'd2, 9, 32'h9ABC_DEF0, ref_shift(2'd2, 9, 32'h9ABC_DEF0), -1);

    // reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 2'd1; shamt = 5'd3; din = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    check_cleared("rst_start");
    reset = 1'b0; start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rs = $urandom_range(0, 31);
      rd = $urandom;
      rinj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, (rs + 3) / 4) : -1;
      run_op($sformatf("rnd%0d", i), ro, rs, rd, ref_shift(ro, rs, rd), rinj);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
